// File: rtl/sender_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// sender_stream_ctrl_if
// Bundles every non-clock/reset signal of the sender stream controller.
//   User side    : data, write, start, clear, abort, loop_mode
//   Serializer   : Transmit, Ready, sdrDataIn
//   External RAM : memDataIn, memDataOut, Address, WriteEnable
//   Status       : count, full, empty, busy, done
// Modports:
//   master : the controller itself (drives strobes, RAM bus and status)
//   slave  : the surrounding environment (user logic, RAM, serializer)
// ---------------------------------------------------------------------------
interface sender_stream_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] data;
  logic              write;
  logic              start;
  logic              clear;
  logic              abort;
  logic              loop_mode;

  logic              Transmit;
  logic              Ready;
  logic [DATA_W-1:0] sdrDataIn;

  logic [DATA_W-1:0] memDataIn;
  logic [DATA_W-1:0] memDataOut;
  logic [ADDR_W-1:0] Address;
  logic              WriteEnable;

  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              busy;
  logic              done;

  modport master (
    input  data, write, start, clear, abort, loop_mode, Ready, memDataOut,
    output Transmit, sdrDataIn, memDataIn, Address, WriteEnable,
           count, full, empty, busy, done
  );

  modport slave (
    output data, write, start, clear, abort, loop_mode, Ready, memDataOut,
    input  Transmit, sdrDataIn, memDataIn, Address, WriteEnable,
           count, full, empty, busy, done
  );
endinterface

// File: rtl/sender_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sender_stream_ctrl
// Buffers user words into an external synchronous single-port RAM, then
// streams them one at a time to a serializer with a Transmit/Ready handshake.
// Supports clear, abort, loop (repeat) mode and a completion pulse.
// Ports:
//   clk   : rising-edge clock
//   Reset : asynchronous, active-high reset (discards buffered words)
//   bus   : sender_stream_ctrl_if.master (user, serializer, RAM, status)
// Every output is registered.
// ---------------------------------------------------------------------------
module sender_stream_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int XMIT_PULSE = 3
) (
  input  logic                 clk,
  input  logic                 Reset,
  sender_stream_ctrl_if.master bus
);

  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH      = CNT_W'(2 ** ADDR_W);
  localparam int                PCNT_W     = (XMIT_PULSE > 1) ? $clog2(XMIT_PULSE) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(XMIT_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ADDR, RD_DATA, LOAD, PULSE, WAIT_BUSY, WAIT_READY
  } state_t;

  // Occupancy never exceeds DEPTH.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == DEPTH) ? c : c + CNT_W'(1);
  endfunction

  state_t              state_q,  state_d;
  logic                tx_q,     tx_d;
  logic                we_q,     we_d;
  logic                done_q,   done_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   sdr_q,    sdr_d;
  logic [DATA_W-1:0]   mdi_q,    mdi_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PCNT_W-1:0]   pcnt_q,   pcnt_d;
  logic                full_q,   full_d;
  logic                empty_q,  empty_d;
  logic                busy_q,   busy_d;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    we_d     = we_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    sdr_d    = sdr_q;
    mdi_d    = mdi_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    pcnt_d   = pcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.write && !full_q) begin
          addr_d  = count_q[ADDR_W-1:0];
          mdi_d   = bus.data;
          we_d    = 1'b1;
          state_d = WR;
        end else if (bus.start && !empty_q) begin
          // Address is presented on entry to RD_ADDR so the RAM samples it
          // at the end of RD_ADDR and data is ready during RD_DATA.
          rd_ptr_d = '0;
          addr_d   = '0;
          state_d  = RD_ADDR;
        end
      end
      WR: begin
        we_d    = 1'b0;
        count_d = sat_inc(count_q);
        state_d = IDLE;
      end
      RD_ADDR: begin
        addr_d  = rd_ptr_q;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        sdr_d   = bus.memDataOut;
        state_d = LOAD;
      end
      LOAD: begin
        if (bus.Ready) begin
          tx_d    = 1'b1;
          pcnt_d  = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (pcnt_q == PULSE_LAST) begin
          tx_d    = 1'b0;
          state_d = WAIT_BUSY;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      WAIT_BUSY: begin
        if (!bus.Ready) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (bus.Ready) begin
          if (({1'b0, rd_ptr_q} + CNT_W'(1)) < count_q) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            addr_d   = rd_ptr_q + ADDR_W'(1);
            state_d  = RD_ADDR;
          end else if (bus.loop_mode) begin
            rd_ptr_d = '0;
            addr_d   = '0;
            state_d  = RD_ADDR;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition; a write caught in WR is dropped
    // by leaving count untouched.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      tx_d    = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b0;
      count_d = count_q;
    end

    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE);
  end

  // State and output register stage
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      tx_q     <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      sdr_q    <= '0;
      mdi_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      pcnt_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      we_q     <= we_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      sdr_q    <= sdr_d;
      mdi_q    <= mdi_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      pcnt_q   <= pcnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.Transmit    = tx_q;
  assign bus.WriteEnable = we_q;
  assign bus.done        = done_q;
  assign bus.Address     = addr_q;
  assign bus.sdrDataIn   = sdr_q;
  assign bus.memDataIn   = mdi_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.busy        = busy_q;

endmodule
